shared_reg_arbiter: RTL and testbench
=====================================

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the shared register width.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, giving the maximum number of writes per grant (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits: per-requester write request, level-sensitive.
REQ-007 The block SHALL have port wdata, input, N_REQ*WIDTH bits: requester i data in bits [i*WIDTH +: WIDTH].
REQ-008 The block SHALL have port clr, input, 1 bit: synchronous clear of the shared register.
REQ-009 The block SHALL have port gnt, output, N_REQ bits: registered one-hot grant, or all zero.
REQ-010 The block SHALL have port busy, output, 1 bit: registered, high while in state OWN.
REQ-011 The block SHALL have port q, output, WIDTH bits: the shared register (bank of D flip-flops).

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and OWN; busy = (state == OWN).
REQ-013 In IDLE with any req bit set, the block SHALL grant the first set req index at or after round-robin pointer ptr (wrapping modulo N_REQ), set gnt one-hot, clear the beat counter and enter OWN at the next edge.
REQ-014 In IDLE the block SHALL never write q from wdata; with req all zero it SHALL stay in IDLE with gnt = 0.
REQ-015 In OWN with owner i and req[i] = 1, each edge SHALL load q from wdata slice i and increment the beat counter.
REQ-016 When the write just performed is write number MAX_BURST, the block SHALL clear gnt, set ptr to (i+1) mod N_REQ and enter IDLE at that same edge.
REQ-017 In OWN with req[i] = 0, the block SHALL perform no write, clear gnt, set ptr to (i+1) mod N_REQ and enter IDLE.
REQ-018 Req bits of non-owners SHALL be ignored while in OWN; no preemption.
REQ-019 Latency SHALL be as follows: req[i] rising in cycle t (IDLE) gives gnt[i] high after edge t+1; the first write of wdata[i] lands on q at edge t+2.
REQ-020 A released requester SHALL be re-eligible one cycle later in IDLE, but only after lower-priority requesters per ptr.
REQ-021 The clr input SHALL have priority over any write in the same cycle: q <= 0, the write is dropped and not counted as a beat, and gnt, state and ptr are unchanged.
REQ-022 When clr coincides with the req[i] drop in OWN, both SHALL take effect: q <= 0 and release per REQ-017.
REQ-023 The beat counter SHALL be ceil(log2(MAX_BURST+1)) bits and SHALL never wrap.
REQ-024 ptr SHALL be ceil(log2(N_REQ)) bits, wrapping from N_REQ-1 to 0.

Reset
REQ-025 With reset = 1 at an edge, the block SHALL set q = 0, gnt = 0, busy = 0, state = IDLE, ptr = 0 and beat = 0, overriding clr, req and an ongoing OWN.
REQ-026 Reset mid-burst SHALL discard that cycle's write; arbitration restarts from ptr = 0 on the first edge with reset = 0.

Structure
REQ-027 Package shared_reg_pkg SHALL hold the state enum (IDLE, OWN) and the default values of N_REQ, WIDTH and MAX_BURST.
REQ-028 A sub-module rr_pick SHALL implement the combinational round-robin selection (inputs req and ptr; outputs a one-hot grant and a valid flag); all registers stay in shared_reg_arbiter.

Verification
REQ-029 Reset and basic grant: reset held 2 cycles, then req=0001 with wdata0=8'hA5 -> gnt=0001 one edge later, q=8'hA5 the next edge, busy=1.
REQ-030 Burst limit: req0 held, MAX_BURST=4, wdata0 = 1,2,3,4,5 on successive cycles -> q takes 1,2,3,4, then gnt=0 and busy=0; 5 is never written.
REQ-031 Round-robin: req=1111 held, 1-beat bursts (req dropped after first write) -> grant order 0,1,2,3,0 with ptr wrapping.
REQ-032 Early release: req2 drops after 2 writes -> gnt clears at the next edge, q keeps the second value, ptr=3.
REQ-033 Clear priority: clr=1 during an OWN write of 8'h3C -> q=0, gnt unchanged, beat count unchanged; clr together with reset -> reset values.
REQ-034 Reset mid-burst: reset asserted at beat 2 of a grant to requester 1 -> all outputs zero; with req=0110 after release, requester 1 is granted first (ptr=0).

Source files
------------

// File: rtl/shared_reg_pkg.sv
// Shared types and default parameters for the round-robin shared-register arbiter.
package shared_reg_pkg;
  localparam int N_REQ_DEF     = 4;
  localparam int WIDTH_DEF     = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // One-hot (up to 8 bits) to index; all-zero input maps to 0.
  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < 8; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction
endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared register arbiter plus FSM debug taps.
interface shared_reg_arbiter_if
  import shared_reg_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
);
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  // Handshake: req[i] is a level "valid" held by requester i; gnt[i] is its
  // "ready". Every edge with req[i] && gnt[i] (and clr low) transfers
  // wdata slice i into q; dropping req[i] while granted releases the grant.
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic                   clr;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [WIDTH-1:0]       q;
  state_e                 dbg_state;
  logic [PTR_W-1:0]       dbg_ptr;
  logic [BEAT_W-1:0]      dbg_beat;

  modport master (
    output req, wdata, clr,
    input  gnt, busy, q, dbg_state, dbg_ptr, dbg_beat
  );

  modport slave (
    input  req, wdata, clr,
    output gnt, busy, q, dbg_state, dbg_ptr, dbg_beat
  );
endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic             valid
);
  always_comb begin
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    gnt_oh = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(N_REQ)) sum = sum - (PTR_W+1)'(N_REQ);
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        gnt_oh[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting bursts of up to MAX_BURST writes into one shared register.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);
  localparam int PTR_W  = $clog2(N_REQ);
  localparam int BEAT_W = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              busy_q, busy_d;

  logic [N_REQ-1:0]  pick_oh;
  logic              pick_valid;
  logic [PTR_W-1:0]  owner, next_ptr;
  logic [WIDTH-1:0]  slices [N_REQ];

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr_q),
    .gnt_oh (pick_oh),
    .valid  (pick_valid)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slices[g] = bus.wdata[g*WIDTH +: WIDTH];
  end

  assign owner    = PTR_W'(oh_to_idx(8'(gnt_q)));
  assign next_ptr = (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + PTR_W'(1);
  assign beat_inc = beat_q + BEAT_W'(1);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = OWN;
          gnt_d   = pick_oh;
          beat_d  = '0;
        end
      end
      OWN: begin
        if (!bus.req[owner]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = next_ptr;
        end else if (!bus.clr) begin
          q_d    = slices[owner];
          beat_d = beat_inc;
          // Release on the same edge as the last permitted write.
          if (beat_inc == BEAT_W'(MAX_BURST)) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = next_ptr;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.clr) q_d = '0;
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.q         = q_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_ptr   = ptr_q;
  assign bus.dbg_beat  = beat_q;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed self-checking bench for shared_reg_arbiter (N_REQ=4, WIDTH=8, MAX_BURST=4).
module tb_shared_reg_arbiter;
  import shared_reg_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) bus ();

  shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.req = '0; bus.clr = 1'b0; bus.wdata = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.req = 4'b1111; bus.clr = 1'b0; bus.wdata = 32'hFFFF_FFFF;
    step(); step();
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected 00", bus.q); end
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.dbg_ptr !== 2'd0 || bus.dbg_state !== IDLE) begin errors++; $display("FAIL reset_ptr_state: got ptr %0d state %0d expected 0 0", bus.dbg_ptr, bus.dbg_state); end
    reset = 1'b0; bus.req = '0; bus.wdata = '0;
  endtask

  task automatic test_basic_grant();
    do_reset();
    bus.req = 4'b0001; bus.wdata = 32'h0000_00A5;
    step();
    checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL basic_gnt: got %b expected 0001", bus.gnt); end
    checks++; if (bus.q !== 8'h00) begin errors++; $display("FAIL basic_no_idle_write: got %h expected 00", bus.q); end
    step();
    checks++; if (bus.q !== 8'hA5 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_write: got q %h busy %b expected a5 1", bus.q, bus.busy); end
    bus.req = '0;
    step();
    checks++; if (bus.gnt !== 4'b0000 || bus.dbg_ptr !== 2'd1) begin errors++; $display("FAIL basic_release: got gnt %b ptr %0d expected 0000 1", bus.gnt, bus.dbg_ptr); end
  endtask

  task automatic test_burst_limit();
    do_reset();
    bus.req = 4'b0001;
    step();
    for (int v = 1; v <= 4; v++) begin
      bus.wdata[7:0] = 8'(v);
      step();
      checks++; if (bus.q !== 8'(v)) begin errors++; $display("FAIL burst_q%0d: got %h expected %h", v, bus.q, 8'(v)); end
      if (v < 4) begin
        checks++; if (bus.busy !== 1'b1 || bus.gnt !== 4'b0001) begin errors++; $display("FAIL burst_own%0d: got busy %b gnt %b expected 1 0001", v, bus.busy, bus.gnt); end
      end else begin
        checks++; if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.dbg_ptr !== 2'd1) begin errors++; $display("FAIL burst_end: got busy %b gnt %b ptr %0d expected 0 0000 1", bus.busy, bus.gnt, bus.dbg_ptr); end
      end
    end
    bus.wdata[7:0] = 8'd5;
    step();
    checks++; if (bus.q !== 8'd4 || bus.gnt !== 4'b0001) begin errors++; $display("FAIL burst_regrant: got q %h gnt %b expected 04 0001", bus.q, bus.gnt); end
    bus.req = '0;
    step();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      int k;
      logic [3:0] eg;
      logic [7:0] eq;
      k = order[n];
      eg = 4'b0001 << k;
      eq = 8'(8'h11 * (k + 1));
      step();
      checks++; if (bus.gnt !== eg) begin errors++; $display("FAIL rr_gnt%0d: got %b expected %b", n, bus.gnt, eg); end
      step();
      checks++; if (bus.q !== eq) begin errors++; $display("FAIL rr_q%0d: got %h expected %h", n, bus.q, eq); end
      bus.req = 4'b1111 & ~eg;
      step();
      checks++; if (bus.gnt !== 4'b0000 || bus.dbg_ptr !== 2'((k + 1) % 4)) begin errors++; $display("FAIL rr_rel%0d: got gnt %b ptr %0d expected 0000 %0d", n, bus.gnt, bus.dbg_ptr, (k + 1) % 4); end
      bus.req = 4'b1111;
    end
    bus.req = '0;
    step(); step();
  endtask

  task automatic test_early_release();
    do_reset();
    bus.req = 4'b0100; bus.wdata[23:16] = 8'h21;
    step();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL early_gnt: got %b expected 0100", bus.gnt); end
    step();
    bus.wdata[23:16] = 8'h22;
    step();
    checks++; if (bus.q !== 8'h22 || bus.dbg_beat !== 3'd2) begin errors++; $display("FAIL early_beat2: got q %h beat %0d expected 22 2", bus.q, bus.dbg_beat); end
    bus.req = '0; bus.wdata[23:16] = 8'h99;
    step();
    checks++; if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 8'h22 || bus.dbg_ptr !== 2'd3) begin errors++; $display("FAIL early_release: got gnt %b busy %b q %h ptr %0d expected 0000 0 22 3", bus.gnt, bus.busy, bus.q, bus.dbg_ptr); end
  endtask

  task automatic test_clear();
    do_reset();
    bus.req = 4'b0001; bus.wdata[7:0] = 8'h11;
    step(); step();
    bus.wdata[7:0] = 8'h3C; bus.clr = 1'b1;
    step();
    checks++; if (bus.q !== 8'h00 || bus.gnt !== 4'b0001 || bus.dbg_beat !== 3'd1 || bus.busy !== 1'b1) begin errors++; $display("FAIL clr_prio: got q %h gnt %b beat %0d busy %b expected 00 0001 1 1", bus.q, bus.gnt, bus.dbg_beat, bus.busy); end
    bus.clr = 1'b0;
    step();
    checks++; if (bus.q !== 8'h3C || bus.dbg_beat !== 3'd2) begin errors++; $display("FAIL clr_after: got q %h beat %0d expected 3c 2", bus.q, bus.dbg_beat); end
    bus.clr = 1'b1; bus.req = '0;
    step();
    checks++; if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.dbg_ptr !== 2'd1) begin errors++; $display("FAIL clr_drop: got q %h gnt %b ptr %0d expected 00 0000 1", bus.q, bus.gnt, bus.dbg_ptr); end
    bus.clr = 1'b0; bus.req = 4'b0001;
    step(); step();
    bus.clr = 1'b1; reset = 1'b1;
    step();
    checks++; if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.dbg_ptr !== 2'd0 || bus.dbg_beat !== 3'd0) begin errors++; $display("FAIL clr_reset: got q %h gnt %b busy %b ptr %0d beat %0d expected all 0", bus.q, bus.gnt, bus.busy, bus.dbg_ptr, bus.dbg_beat); end
    reset = 1'b0; bus.clr = 1'b0; bus.req = '0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    bus.req = 4'b0010; bus.wdata[15:8] = 8'h5A;
    step(); step();
    checks++; if (bus.q !== 8'h5A || bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_beat1: got q %h gnt %b expected 5a 0010", bus.q, bus.gnt); end
    bus.wdata[15:8] = 8'h6B; reset = 1'b1;
    step();
    checks++; if (bus.q !== 8'h00 || bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.dbg_ptr !== 2'd0) begin errors++; $display("FAIL mid_reset: got q %h gnt %b busy %b ptr %0d expected 00 0000 0 0", bus.q, bus.gnt, bus.busy, bus.dbg_ptr); end
    reset = 1'b0; bus.req = 4'b0110;
    step();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_regrant: got %b expected 0010", bus.gnt); end
    bus.req = '0;
    step();
  endtask

  initial begin
    bus.req = '0; bus.clr = 1'b0; bus.wdata = '0;
    test_reset();
    test_basic_grant();
    test_burst_limit();
    test_round_robin();
    test_early_release();
    test_clear();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
